// File: rtl/write_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module : write_guard_pkg
// Brief  : Shared types, fault codes and ID-table entry layout for write_guard.
// Rev    : 1.0
// ============================================================================
package write_guard_pkg;

   typedef logic [7:0]  guard_id_t;
   typedef logic [5:0]  guard_num_t;
   typedef logic [15:0] guard_cnt_t;

   typedef struct packed {
      logic      aw_valid;
      guard_id_t aw_id;
      logic      w_valid;
      logic      b_ready;
   } guard_req_t;

   typedef struct packed {
      logic      aw_ready;
      logic      w_ready;
      logic      b_valid;
      guard_id_t b_id;
   } guard_rsp_t;

   typedef struct packed {
      guard_id_t  id;
      guard_num_t num_txn;
      guard_cnt_t counter;
      logic       free;
   } entry_t;

   localparam logic [1:0] c_ERR_NONE       = 2'b00;
   localparam logic [1:0] c_ERR_TIMEOUT    = 2'b01;
   localparam logic [1:0] c_ERR_OVERFLOW   = 2'b10;
   localparam logic [1:0] c_ERR_UNKNOWN_ID = 2'b11;

endpackage
`default_nettype wire

// File: rtl/write_guard_wr_counter.sv
`default_nettype none
// ============================================================================
// Module : wr_counter
// Brief  : One ID-table entry: outstanding count, response budget and free flag.
// Rev    : 1.0
// ============================================================================
module wr_counter
   import write_guard_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic       tick_i,
   input  logic       load_i,
   input  logic       inc_i,
   input  logic       dec_i,
   input  guard_id_t  id_i,
   input  guard_cnt_t budget_i,
   output entry_t     entry_o,
   output logic       saturated_o,
   output logic       timeout_o
);

   localparam entry_t c_EMPTY = '{id: '0, num_txn: '0, counter: '0, free: 1'b1};

   entry_t r_entry;
   logic   w_saturated;

   assign w_saturated = &r_entry.num_txn;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_entry <= c_EMPTY;
      end else if (clear_i) begin
         r_entry <= c_EMPTY;
      end else if (load_i) begin
         r_entry.id      <= id_i;
         r_entry.num_txn <= guard_num_t'(1);
         r_entry.counter <= budget_i;
         r_entry.free    <= 1'b0;
      end else if (!r_entry.free) begin
         if (dec_i) begin
            // A coincident AW on the same ID cancels the B, keeping the entry live
            r_entry.counter <= budget_i;
            if (!inc_i) begin
               r_entry.num_txn <= r_entry.num_txn - guard_num_t'(1);
               if (r_entry.num_txn == guard_num_t'(1))
                  r_entry.free <= 1'b1;
            end
         end else begin
            if (inc_i && !w_saturated)
               r_entry.num_txn <= r_entry.num_txn + guard_num_t'(1);
            if (tick_i && (r_entry.counter != '0))
               r_entry.counter <= r_entry.counter - guard_cnt_t'(1);
         end
      end
   end

   assign entry_o     = r_entry;
   assign saturated_o = w_saturated;
   assign timeout_o   = !r_entry.free && tick_i && (r_entry.counter == '0);

endmodule
`default_nettype wire

// File: rtl/write_guard.sv
`default_nettype none
// ============================================================================
// Module : write_guard
// Brief  : AXI write watchdog; tracks outstanding AW IDs and flags B timeouts,
//          table overflow and unknown B IDs as a sticky reset request.
// Rev    : 1.0
// ============================================================================
module write_guard
   import write_guard_pkg::*;
#(
   parameter int unsigned MaxUniqIds   = 32,
   parameter int unsigned MaxWrTxns    = 32,
   parameter int unsigned PrescalerDiv = 1,
   parameter type req_t       = guard_req_t,
   parameter type rsp_t       = guard_rsp_t,
   parameter type id_t        = guard_id_t,
   parameter type num_cnt_t   = guard_num_t,
   parameter type track_cnt_t = guard_cnt_t
)(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_en_i,
   input  track_cnt_t budget_i,
   input  req_t       mst_req_i,
   input  rsp_t       slv_rsp_i,
   input  logic       reset_clear_i,
   output logic       reset_req_o,
   output logic       irq_o,
   output logic [1:0] err_o,
   output id_t        err_id_o
);

   localparam int unsigned ID_CAPACITY = (MaxUniqIds < MaxWrTxns) ? MaxUniqIds : MaxWrTxns;
   localparam int unsigned PRESC_W     = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;

   assign w_tick = (r_presc == PRESC_W'(PrescalerDiv - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + PRESC_W'(1);
   end

   logic w_aw_hs, w_b_hs, w_alloc, w_ovf, w_unk, w_unused;
   logic [ID_CAPACITY-1:0] w_free_vec, w_free_oh, w_aw_match, w_b_match;
   logic [ID_CAPACITY-1:0] w_load, w_inc, w_dec, w_sat, w_timeout, w_to_oh;
   entry_t w_entry [ID_CAPACITY];

   assign w_aw_hs  = wr_en_i && mst_req_i.aw_valid && slv_rsp_i.aw_ready;
   assign w_b_hs   = slv_rsp_i.b_valid && mst_req_i.b_ready;
   assign w_unused = mst_req_i.w_valid ^ slv_rsp_i.w_ready;

   // Two's-complement trick isolates the lowest set bit without an index encoder
   assign w_free_oh = w_free_vec & (~w_free_vec + ID_CAPACITY'(1));
   assign w_to_oh   = w_timeout  & (~w_timeout  + ID_CAPACITY'(1));
   assign w_alloc   = w_aw_hs && !(|w_aw_match) && (|w_free_vec);
   assign w_ovf     = w_aw_hs && ((!(|w_aw_match) && !(|w_free_vec)) || (|(w_inc & w_sat & ~w_dec)));
   assign w_unk     = w_b_hs && !(|w_b_match);

   generate
      for (genvar i = 0; i < ID_CAPACITY; i++) begin : g_entry
         assign w_free_vec[i] = w_entry[i].free;
         assign w_aw_match[i] = !w_entry[i].free && (w_entry[i].id == mst_req_i.aw_id);
         assign w_b_match[i]  = !w_entry[i].free && (w_entry[i].id == slv_rsp_i.b_id);
         assign w_load[i]     = w_alloc && w_free_oh[i];
         assign w_inc[i]      = w_aw_hs && w_aw_match[i];
         assign w_dec[i]      = w_b_hs && w_b_match[i];

         wr_counter u_counter (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clear_i     (reset_clear_i),
            .tick_i      (w_tick),
            .load_i      (w_load[i]),
            .inc_i       (w_inc[i]),
            .dec_i       (w_dec[i]),
            .id_i        (mst_req_i.aw_id),
            .budget_i    (budget_i),
            .entry_o     (w_entry[i]),
            .saturated_o (w_sat[i]),
            .timeout_o   (w_timeout[i])
         );
      end
   endgenerate

   id_t        w_to_id, w_fault_id;
   logic       w_fault;
   logic [1:0] w_code;

   always_comb begin
      w_to_id = '0;
      for (int i = 0; i < ID_CAPACITY; i++)
         if (w_to_oh[i]) w_to_id = w_to_id | w_entry[i].id;
   end

   always_comb begin
      w_fault    = 1'b1;
      w_code     = c_ERR_NONE;
      w_fault_id = '0;
      if (|w_timeout) begin
         w_code     = c_ERR_TIMEOUT;
         w_fault_id = w_to_id;
      end else if (w_ovf) begin
         w_code     = c_ERR_OVERFLOW;
         w_fault_id = mst_req_i.aw_id;
      end else if (w_unk) begin
         w_code     = c_ERR_UNKNOWN_ID;
         w_fault_id = slv_rsp_i.b_id;
      end else begin
         w_fault    = 1'b0;
      end
   end

   logic       r_reset_req, r_irq;
   logic [1:0] r_err;
   id_t        r_err_id;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i || reset_clear_i) begin
         r_reset_req <= 1'b0;
         r_irq       <= 1'b0;
         r_err       <= c_ERR_NONE;
         r_err_id    <= '0;
      end else begin
         r_irq <= 1'b0;
         if (w_fault && !r_reset_req) begin
            r_reset_req <= 1'b1;
            r_irq       <= 1'b1;
            r_err       <= w_code;
            r_err_id    <= w_fault_id;
         end
      end
   end

   assign reset_req_o = r_reset_req;
   assign irq_o       = r_irq;
   assign err_o       = r_err;
   assign err_id_o    = r_err_id;

endmodule
`default_nettype wire
